ct_clint_ncore: RTL and testbench
=================================

CT_CLINT_NCORE -- requirements
Module: ct_clint_ncore

Interface
REQ-001 SHALL have parameter NUM_CORE, default 4, range 1..16: number of harts served.
REQ-002 SHALL have parameter CMP_RST, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of every timecmp register.
REQ-003 SHALL have ports forever_apbclk, input, 1: sole clock; all flops on its rising edge.
REQ-004 SHALL have ports cpurst_b, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports psel_clint / penable / pwrite, input, 1 each: APB control.
REQ-006 SHALL have ports paddr, input, 32 (bits [15:0] decoded); pwdata, input, 32; pprot, input, 2 (00 U, 01 S, 11 M).
REQ-007 SHALL have ports prdata_clint, output, 32; pready_clint, output, 1; perr_clint, output, 1.
REQ-008 SHALL have ports sysio_clint_mtime, input, 64; mtime_upd_en, input, 1 (sample strobe).
REQ-009 SHALL have ports clint_ms_int / clint_mt_int / clint_ss_int / clint_st_int, output, NUM_CORE each, bit i = hart i.

Function
REQ-010 SHALL map hart i at MSIP 0x0000+4i, MTIMECMP lo/hi 0x4000+8i / 0x4004+8i, SSIP 0xC000+4i, STIMECMP lo/hi 0xD000+8i / 0xD004+8i.
REQ-011 SHALL flag acc_err for any paddr[15:0] not in REQ-010 for i<NUM_CORE (REQ-024 excepted).
REQ-012 SHALL flag priv_err for 0x0xxx/0x4xxx without pprot=11, and for 0xBxxx/0xCxxx/0xDxxx with pprot=00.
REQ-013 SHALL run a 2-state APB FSM: IDLE -> ACCESS on psel&!penable; ACCESS -> IDLE unconditionally after one cycle.
REQ-014 SHALL drive pready_clint=1 only in ACCESS, one cycle after setup, registered; zero wait states.
REQ-015 SHALL drive perr_clint=1 in ACCESS iff acc_err|priv_err was registered at setup.
REQ-016 SHALL commit writes in ACCESS when psel&penable&pwrite and no error; erroneous writes are dropped, no state change.
REQ-017 SHALL store MSIP/SSIP from pwdata[0]; reads return {31'b0,bit}.
REQ-018 SHALL store timecmp halves as full 32-bit words.
REQ-019 SHALL return prdata_clint=0 for errored or undecoded reads, never X.
REQ-020 SHALL sample sysio_clint_mtime into mtime_q when mtime_upd_en=1, else hold.
REQ-021 SHALL register mt_int[i] = ({mtimecmph,mtimecmp}[i] <= mtime_q), likewise st_int[i] (unsigned 64-bit).
REQ-021a Latency SHALL be one cycle after mtime_q update or cmp write.
REQ-022 SHALL drive ms_int/ss_int directly from MSIP/SSIP flops, no extra latency.
REQ-023 mtime_q SHALL update while an APB write lands in the same cycle; both effects SHALL be visible in the next compare.

Reset
REQ-024 SHALL on cpurst_b=0 immediately put FSM in IDLE with pready_clint=0, perr_clint=0, prdata_clint=0.
REQ-024a On reset all MSIP/SSIP=0, all timecmp=CMP_RST, mtime_q=0, mt_int/st_int=0; reset mid-access SHALL abort with no write.

Configuration
REQ-025 Macro CLINT_MTIME_RD_EN defined: SHALL map mtime_q at 0xBFF8 (lo) and 0xBFFC (hi), read-only, S or M.
REQ-025a With the macro, reading 0xBFF8 SHALL latch mtime_q[63:32] into shadow, and 0xBFFC SHALL return shadow; writes SHALL return perr_clint=1.
REQ-026 Macro undefined: 0xBFF8/0xBFFC SHALL be acc_err and no shadow flops SHALL exist.

Structure
REQ-027 Package ct_clint_pkg SHALL hold region bases, per-hart strides, MTIME_LO/HI offsets and the FSM state typedef.
REQ-028 SHALL instantiate sub-module ct_clint_hart_regs NUM_CORE times (per-hart regs, write decode, compare flops); top holds APB FSM, error decode, read mux, mtime_q.

Verification
REQ-029 M write 0x0000_0005 to 0x4008, 0 to 0x400C, mtime=5 strobed -> clint_mt_int[1]=1 one cycle after mtime_q=5; mtime=4 -> 0.
REQ-030 pprot=01 write 1 to 0x0004 -> perr_clint=1 with pready_clint, clint_ms_int[1] stays 0.
REQ-031 pprot=00 write 1 to 0xC000 -> perr_clint=1, clint_ss_int[0] stays 0; pprot=01 retry -> ss_int[0]=1, perr_clint=0.
REQ-032 NUM_CORE=2, read 0x4010 -> perr_clint=1, prdata_clint=0.
REQ-033 CLINT_MTIME_RD_EN, mtime_q=0x1_FFFF_FFFF, read 0xBFF8 -> 0xFFFF_FFFF; mtime to 0x2_0000_0000; read 0xBFFC -> 0x1.
REQ-034 Assert cpurst_b=0 during ACCESS of a write to 0x4000 -> no pready_clint, mtimecmp0=CMP_RST, all int outputs 0.

Source files
------------

// File: rtl/ct_clint_ncore_pkg.sv
// ct_clint_pkg -- shared definitions for the multi-hart CLINT.
// Holds the region bases, per-hart strides, the mtime mirror offsets, the APB FSM
// state type and the register decode helper used by the top and the per-hart block.
// Optional feature macro (consumed by the top): CLINT_MTIME_RD_EN.
package ct_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] SSIP_BASE     = 16'hC000;
    localparam logic [15:0] STIMECMP_BASE = 16'hD000;
    localparam int          SIP_STRIDE    = 4;
    localparam int          CMP_STRIDE    = 8;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    typedef enum logic {ST_IDLE, ST_ACCESS} apb_state_e;

    typedef enum logic [2:0] {
        RK_NONE, RK_MSIP, RK_MTCMP, RK_SSIP, RK_STCMP, RK_MTIME_LO, RK_MTIME_HI
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [3:0] idx;   // hart number
        logic       hi;    // upper half of a 64-bit compare register
    } reg_dec_t;

    // Per-hart register decode of paddr[15:0]; RK_NONE for anything outside
    // the populated harts or not word aligned.
    function automatic reg_dec_t decode_hart(input logic [15:0] a, input int num_core);
        reg_dec_t   d;
        logic [11:0] off;
        d.kind = RK_NONE;
        d.idx  = '0;
        d.hi   = 1'b0;
        off    = a[11:0];
        if (off[1:0] == 2'b00) begin
            if (a[15:12] == MSIP_BASE[15:12] || a[15:12] == SSIP_BASE[15:12]) begin
                if (int'(off) / SIP_STRIDE < num_core) begin
                    d.kind = (a[15:12] == MSIP_BASE[15:12]) ? RK_MSIP : RK_SSIP;
                    d.idx  = 4'(int'(off) / SIP_STRIDE);
                end
            end else if (a[15:12] == MTIMECMP_BASE[15:12] || a[15:12] == STIMECMP_BASE[15:12]) begin
                if (int'(off) / CMP_STRIDE < num_core) begin
                    d.kind = (a[15:12] == MTIMECMP_BASE[15:12]) ? RK_MTCMP : RK_STCMP;
                    d.idx  = 4'(int'(off) / CMP_STRIDE);
                    d.hi   = off[2];
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ct_clint_ncore_if.sv
// ct_clint_ncore_if -- APB slave bus of the CLINT.
// master: drives psel_clint/penable/pwrite/paddr/pwdata/pprot.
// slave : drives prdata_clint/pready_clint/perr_clint.
interface ct_clint_ncore_if;
    logic        psel_clint;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [1:0]  pprot;
    logic [31:0] prdata_clint;
    logic        pready_clint;
    logic        perr_clint;

    modport master (
        output psel_clint, penable, pwrite, paddr, pwdata, pprot,
        input  prdata_clint, pready_clint, perr_clint
    );
    modport slave (
        input  psel_clint, penable, pwrite, paddr, pwdata, pprot,
        output prdata_clint, pready_clint, perr_clint
    );
endinterface

// File: rtl/ct_clint_hart_regs.sv
// ct_clint_hart_regs -- registers of one hart: MSIP, SSIP, mtimecmp, stimecmp
// and the registered timer compares.
// Ports: clk/rst_n, wr_en (committed APB write), dec (decoded target), wdata,
//        mtime (sampled time), msip/ssip, mtimecmp/stimecmp, mt_int/st_int.
module ct_clint_hart_regs
    import ct_clint_pkg::*;
#(
    parameter int          HART_ID = 0,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  reg_dec_t    dec,
    input  logic [31:0] wdata,
    input  logic [63:0] mtime,
    output logic        msip,
    output logic        ssip,
    output logic [63:0] mtimecmp,
    output logic [63:0] stimecmp,
    output logic        mt_int,
    output logic        st_int
);

    logic sel;
    assign sel = wr_en && (dec.idx == 4'(HART_ID));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip     <= 1'b0;
            ssip     <= 1'b0;
            mtimecmp <= CMP_RST;
            stimecmp <= CMP_RST;
            mt_int   <= 1'b0;
            st_int   <= 1'b0;
        end else begin
            if (sel) begin
                case (dec.kind)
                    RK_MSIP:  msip <= wdata[0];
                    RK_SSIP:  ssip <= wdata[0];
                    RK_MTCMP: if (dec.hi) mtimecmp[63:32] <= wdata; else mtimecmp[31:0] <= wdata;
                    RK_STCMP: if (dec.hi) stimecmp[63:32] <= wdata; else stimecmp[31:0] <= wdata;
                    default: ;
                endcase
            end
            // Compares use current register values, so a new mtime or cmp
            // shows up on the interrupt one cycle after it lands.
            mt_int <= (mtimecmp <= mtime);
            st_int <= (stimecmp <= mtime);
        end
    end

endmodule

// File: rtl/ct_clint_ncore.sv
// ct_clint_ncore -- CLINT for NUM_CORE harts behind a zero-wait-state APB slave.
// Ports: forever_apbclk, cpurst_b (async, active low), apb (slave modport),
//        sysio_clint_mtime/mtime_upd_en (time sample), clint_{ms,mt,ss,st}_int.
// Macro CLINT_MTIME_RD_EN: adds read-only mtime mirror at 0xBFF8/0xBFFC with a
// high-word shadow latched on the low-word read.
module ct_clint_ncore
    import ct_clint_pkg::*;
#(
    parameter int          NUM_CORE = 4,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                forever_apbclk,
    input  logic                cpurst_b,
    ct_clint_ncore_if.slave     apb,
    input  logic [63:0]         sysio_clint_mtime,
    input  logic                mtime_upd_en,
    output logic [NUM_CORE-1:0] clint_ms_int,
    output logic [NUM_CORE-1:0] clint_mt_int,
    output logic [NUM_CORE-1:0] clint_ss_int,
    output logic [NUM_CORE-1:0] clint_st_int
);

    apb_state_e  state;
    logic        pready_q, perr_q, err_q;
    logic [31:0] prdata_q;
    logic [63:0] mtime_q;
    logic [15:0] a;
    logic [3:0]  rgn;
    reg_dec_t    dec;
    logic        setup, acc_err, priv_err, err, wr_en;
    logic [31:0] rdata;
    logic [NUM_CORE-1:0][63:0] mtcmp, stcmp;
    logic        unused_ok;

    assign a         = apb.paddr[15:0];
    assign rgn       = a[15:12];
    assign unused_ok = ^apb.paddr[31:16];

`ifdef CLINT_MTIME_RD_EN
    logic [31:0] mtime_shadow;
`endif

    always_comb begin
        dec = decode_hart(a, NUM_CORE);
`ifdef CLINT_MTIME_RD_EN
        // Mirror is read-only: a write never decodes, so it reports perr.
        if (!apb.pwrite) begin
            if (a == MTIME_LO)      dec.kind = RK_MTIME_LO;
            else if (a == MTIME_HI) dec.kind = RK_MTIME_HI;
        end
`endif
    end

    assign acc_err  = (dec.kind == RK_NONE);
    assign priv_err = ((rgn == MSIP_BASE[15:12] || rgn == MTIMECMP_BASE[15:12]) && apb.pprot != 2'b11) ||
                      ((rgn == MTIME_LO[15:12] || rgn == SSIP_BASE[15:12] || rgn == STIMECMP_BASE[15:12]) &&
                       apb.pprot == 2'b00);
    assign err      = acc_err | priv_err;
    assign setup    = apb.psel_clint & ~apb.penable;
    // Address and data are held stable through ACCESS, so the live decode is
    // used for the write; only the error verdict is taken from setup.
    assign wr_en    = (state == ST_ACCESS) && apb.psel_clint && apb.penable && apb.pwrite && !err_q;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CORE; i++) begin
            if (dec.idx == 4'(i)) begin
                case (dec.kind)
                    RK_MSIP:  rdata = {31'b0, clint_ms_int[i]};
                    RK_SSIP:  rdata = {31'b0, clint_ss_int[i]};
                    RK_MTCMP: rdata = dec.hi ? mtcmp[i][63:32] : mtcmp[i][31:0];
                    RK_STCMP: rdata = dec.hi ? stcmp[i][63:32] : stcmp[i][31:0];
                    default: ;
                endcase
            end
        end
`ifdef CLINT_MTIME_RD_EN
        if (dec.kind == RK_MTIME_LO) rdata = mtime_q[31:0];
        if (dec.kind == RK_MTIME_HI) rdata = mtime_shadow;
`endif
    end

    // APB FSM; response flops are loaded at setup so they are valid for the
    // whole ACCESS cycle and cleared otherwise.
    always_ff @(posedge forever_apbclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= ST_IDLE;
            pready_q <= 1'b0;
            perr_q   <= 1'b0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            pready_q <= 1'b0;
            perr_q   <= 1'b0;
            prdata_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        state    <= ST_ACCESS;
                        pready_q <= 1'b1;
                        perr_q   <= err;
                        err_q    <= err;
                        prdata_q <= (err || apb.pwrite) ? 32'h0 : rdata;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CLINT_MTIME_RD_EN
    // Low-word read freezes the high word so a split 64-bit read is coherent.
    always_ff @(posedge forever_apbclk or negedge cpurst_b) begin
        if (!cpurst_b)
            mtime_shadow <= '0;
        else if (state == ST_IDLE && setup && !err && dec.kind == RK_MTIME_LO)
            mtime_shadow <= mtime_q[63:32];
    end
`endif

    always_ff @(posedge forever_apbclk or negedge cpurst_b) begin
        if (!cpurst_b)         mtime_q <= '0;
        else if (mtime_upd_en) mtime_q <= sysio_clint_mtime;
    end

    assign apb.pready_clint = pready_q;
    assign apb.perr_clint   = perr_q;
    assign apb.prdata_clint = prdata_q;

    for (genvar i = 0; i < NUM_CORE; i++) begin : g_hart
        ct_clint_hart_regs #(
            .HART_ID (i),
            .CMP_RST (CMP_RST)
        ) u_hart (
            .clk      (forever_apbclk),
            .rst_n    (cpurst_b),
            .wr_en    (wr_en),
            .dec      (dec),
            .wdata    (apb.pwdata),
            .mtime    (mtime_q),
            .msip     (clint_ms_int[i]),
            .ssip     (clint_ss_int[i]),
            .mtimecmp (mtcmp[i]),
            .stimecmp (stcmp[i]),
            .mt_int   (clint_mt_int[i]),
            .st_int   (clint_st_int[i])
        );
    end

endmodule

// File: tb/tb_ct_clint_ncore.sv
// tb_ct_clint_ncore -- directed bench for ct_clint_ncore with two harts.
module tb_ct_clint_ncore;
    localparam int NC = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   mtime = '0;
    logic          upd   = 1'b0;
    logic [NC-1:0] ms, mt, ss, st;
    logic [31:0]   rd;
    logic          er, rdy;
    int            n_cmp = 0;
    int            n_bad = 0;

    ct_clint_ncore_if bus();

    ct_clint_ncore #(.NUM_CORE(NC)) dut (
        .forever_apbclk    (clk),
        .cpurst_b          (rst_n),
        .apb               (bus),
        .sysio_clint_mtime (mtime),
        .mtime_upd_en      (upd),
        .clint_ms_int      (ms),
        .clint_mt_int      (mt),
        .clint_ss_int      (ss),
        .clint_st_int      (st)
    );

    always #5 clk = ~clk;

    task automatic bus_idle;
        bus.psel_clint = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pprot = 2'b11;
    endtask

    // One APB transfer; response sampled at the negedge inside ACCESS.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] prot);
        @(negedge clk);
        bus.psel_clint = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = data; bus.pprot = prot;
        @(negedge clk);
        bus.penable = 1'b1;
        rd = bus.prdata_clint; er = bus.perr_clint; rdy = bus.pready_clint;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic set_mtime(input logic [63:0] v);
        @(negedge clk); mtime = v; upd = 1'b1;
        @(negedge clk); upd = 1'b0;
    endtask

    task automatic test_reset;
        bus_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.pready_clint !== 1'b0) begin n_bad++; $display("FAIL rst_pready: got %b want 0", bus.pready_clint); end
        n_cmp++; if (bus.perr_clint !== 1'b0) begin n_bad++; $display("FAIL rst_perr: got %b want 0", bus.perr_clint); end
        n_cmp++; if (bus.prdata_clint !== 32'h0) begin n_bad++; $display("FAIL rst_prdata: got %h want 0", bus.prdata_clint); end
        n_cmp++; if ({ms, mt, ss, st} !== 8'h0) begin n_bad++; $display("FAIL rst_ints: got %h want 00", {ms, mt, ss, st}); end
        rst_n = 1'b1;
        @(negedge clk);
        apb_xfer(1'b0, 32'h0000_4000, 32'h0, 2'b11);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp0_lo: got %h want ffffffff", rd); end
        n_cmp++; if (rdy !== 1'b1 || er !== 1'b0) begin n_bad++; $display("FAIL rst_rd_resp: got rdy=%b err=%b want 1/0", rdy, er); end
        n_cmp++; if (bus.pready_clint !== 1'b0) begin n_bad++; $display("FAIL idle_pready: got %b want 0", bus.pready_clint); end
        apb_xfer(1'b0, 32'h0000_400C, 32'h0, 2'b11);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_cmp1_hi: got %h want ffffffff", rd); end
    endtask

    task automatic test_mtimecmp;
        apb_xfer(1'b1, 32'h0000_4008, 32'h0000_0005, 2'b11);
        n_cmp++; if (rdy !== 1'b1 || er !== 1'b0) begin n_bad++; $display("FAIL mtcmp_wr_resp: got rdy=%b err=%b want 1/0", rdy, er); end
        apb_xfer(1'b1, 32'h0000_400C, 32'h0, 2'b11);
        apb_xfer(1'b0, 32'h0000_4008, 32'h0, 2'b11);
        n_cmp++; if (rd !== 32'h5) begin n_bad++; $display("FAIL mtcmp_rdback: got %h want 5", rd); end
        set_mtime(64'd5);
        n_cmp++; if (mt !== 2'b00) begin n_bad++; $display("FAIL mt_latency: got %b want 00", mt); end
        @(negedge clk);
        n_cmp++; if (mt !== 2'b10) begin n_bad++; $display("FAIL mt_eq: got %b want 10", mt); end
        set_mtime(64'd4);
        @(negedge clk);
        n_cmp++; if (mt !== 2'b00) begin n_bad++; $display("FAIL mt_below: got %b want 00", mt); end
        set_mtime(64'h1_0000_0000);
        @(negedge clk);
        n_cmp++; if (mt !== 2'b10) begin n_bad++; $display("FAIL mt_hiword: got %b want 10", mt); end
        set_mtime(64'd0);
        @(negedge clk);
        n_cmp++; if (mt !== 2'b00) begin n_bad++; $display("FAIL mt_zero: got %b want 00", mt); end
    endtask

    task automatic test_msip;
        apb_xfer(1'b1, 32'h0000_0004, 32'h1, 2'b01);
        n_cmp++; if (er !== 1'b1 || rdy !== 1'b1) begin n_bad++; $display("FAIL msip_s_wr: got err=%b rdy=%b want 1/1", er, rdy); end
        n_cmp++; if (ms !== 2'b00) begin n_bad++; $display("FAIL msip_s_dropped: got %b want 00", ms); end
        apb_xfer(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 2'b11);
        n_cmp++; if (ms !== 2'b10) begin n_bad++; $display("FAIL msip_m_wr: got %b want 10", ms); end
        apb_xfer(1'b0, 32'h0000_0004, 32'h0, 2'b01);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL msip_s_rd: got err=%b data=%h want 1/0", er, rd); end
        apb_xfer(1'b0, 32'h0000_0004, 32'h0, 2'b11);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL msip_rd: got %h want 1", rd); end
        apb_xfer(1'b1, 32'h0000_0004, 32'h0, 2'b11);
        n_cmp++; if (ms !== 2'b00) begin n_bad++; $display("FAIL msip_clr: got %b want 00", ms); end
    endtask

    task automatic test_ssip;
        apb_xfer(1'b1, 32'h0000_C000, 32'h1, 2'b00);
        n_cmp++; if (er !== 1'b1 || ss !== 2'b00) begin n_bad++; $display("FAIL ssip_u_wr: got err=%b ss=%b want 1/00", er, ss); end
        apb_xfer(1'b1, 32'h0000_C000, 32'h1, 2'b01);
        n_cmp++; if (er !== 1'b0 || ss !== 2'b01) begin n_bad++; $display("FAIL ssip_s_wr: got err=%b ss=%b want 0/01", er, ss); end
        apb_xfer(1'b1, 32'h0000_C004, 32'h3, 2'b11);
        n_cmp++; if (ss !== 2'b11) begin n_bad++; $display("FAIL ssip_h1_wr: got %b want 11", ss); end
        apb_xfer(1'b0, 32'h0000_C004, 32'h0, 2'b01);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL ssip_rd: got %h want 1", rd); end
    endtask

    task automatic test_stimecmp;
        apb_xfer(1'b1, 32'h0000_D000, 32'h20, 2'b01);
        apb_xfer(1'b1, 32'h0000_D004, 32'h0, 2'b01);
        apb_xfer(1'b0, 32'h0000_D000, 32'h0, 2'b01);
        n_cmp++; if (rd !== 32'h20 || er !== 1'b0) begin n_bad++; $display("FAIL stcmp_rd: got %h err=%b want 20/0", rd, er); end
        apb_xfer(1'b0, 32'h0000_D000, 32'h0, 2'b00);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL stcmp_u_rd: got err=%b data=%h want 1/0", er, rd); end
        set_mtime(64'h1F);
        @(negedge clk);
        n_cmp++; if (st !== 2'b00) begin n_bad++; $display("FAIL st_below: got %b want 00", st); end
        set_mtime(64'h20);
        @(negedge clk);
        n_cmp++; if (st !== 2'b01) begin n_bad++; $display("FAIL st_eq: got %b want 01", st); end
    endtask

    task automatic test_acc_err;
        apb_xfer(1'b0, 32'h0000_4010, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0 || rdy !== 1'b1) begin n_bad++; $display("FAIL acc_4010: got err=%b data=%h rdy=%b want 1/0/1", er, rd, rdy); end
        apb_xfer(1'b0, 32'h0000_0008, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL acc_msip2: got err=%b want 1", er); end
        apb_xfer(1'b0, 32'h0000_4009, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL acc_misalign: got err=%b want 1", er); end
        apb_xfer(1'b0, 32'h0000_8000, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL acc_hole: got err=%b want 1", er); end
        apb_xfer(1'b0, 32'hABCD_4008, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b0 || rd !== 32'h5) begin n_bad++; $display("FAIL upper_addr_ignored: got err=%b data=%h want 0/5", er, rd); end
    endtask

    // Cmp write and mtime strobe commit on the same edge.
    task automatic test_concurrent;
        apb_xfer(1'b1, 32'h0000_4004, 32'h0, 2'b11);
        @(negedge clk);
        bus.psel_clint = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h0000_4000; bus.pwdata = 32'h40; bus.pprot = 2'b11;
        @(negedge clk);
        bus.penable = 1'b1; mtime = 64'h40; upd = 1'b1;
        @(negedge clk);
        bus_idle(); upd = 1'b0;
        n_cmp++; if (mt !== 2'b10) begin n_bad++; $display("FAIL conc_latency: got %b want 10", mt); end
        @(negedge clk);
        n_cmp++; if (mt !== 2'b11) begin n_bad++; $display("FAIL conc_both: got %b want 11", mt); end
    endtask

    task automatic test_mtime_rd;
`ifdef CLINT_MTIME_RD_EN
        set_mtime(64'h1_FFFF_FFFF);
        apb_xfer(1'b0, 32'h0000_BFF8, 32'h0, 2'b01);
        n_cmp++; if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin n_bad++; $display("FAIL mtime_lo: got %h err=%b want ffffffff/0", rd, er); end
        set_mtime(64'h2_0000_0000);
        apb_xfer(1'b0, 32'h0000_BFFC, 32'h0, 2'b11);
        n_cmp++; if (rd !== 32'h1 || er !== 1'b0) begin n_bad++; $display("FAIL mtime_shadow: got %h err=%b want 1/0", rd, er); end
        apb_xfer(1'b1, 32'h0000_BFF8, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mtime_wr: got err=%b want 1", er); end
        apb_xfer(1'b0, 32'h0000_BFF8, 32'h0, 2'b00);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mtime_u_rd: got err=%b data=%h want 1/0", er, rd); end
`else
        set_mtime(64'h1_FFFF_FFFF);
        apb_xfer(1'b0, 32'h0000_BFF8, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mtime_lo_absent: got err=%b data=%h want 1/0", er, rd); end
        apb_xfer(1'b0, 32'h0000_BFFC, 32'h0, 2'b11);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL mtime_hi_absent: got err=%b data=%h want 1/0", er, rd); end
`endif
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        bus.psel_clint = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h0000_4000; bus.pwdata = 32'h0; bus.pprot = 2'b11;
        @(negedge clk);
        bus.penable = 1'b1;
        n_cmp++; if (bus.pready_clint !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_pready: got %b want 1", bus.pready_clint); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.pready_clint !== 1'b0 || bus.perr_clint !== 1'b0) begin n_bad++; $display("FAIL midrst_resp: got rdy=%b err=%b want 0/0", bus.pready_clint, bus.perr_clint); end
        n_cmp++; if ({ms, mt, ss, st} !== 8'h0) begin n_bad++; $display("FAIL midrst_ints: got %h want 00", {ms, mt, ss, st}); end
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        apb_xfer(1'b0, 32'h0000_4000, 32'h0, 2'b11);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midrst_cmp0_lo: got %h want ffffffff", rd); end
        apb_xfer(1'b0, 32'h0000_4004, 32'h0, 2'b11);
        n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL midrst_cmp0_hi: got %h want ffffffff", rd); end
        n_cmp++; if ({ms, mt, ss, st} !== 8'h0) begin n_bad++; $display("FAIL postrst_ints: got %h want 00", {ms, mt, ss, st}); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_mtimecmp();
        test_msip();
        test_ssip();
        test_stimecmp();
        test_acc_err();
        test_concurrent();
        test_mtime_rd();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
